count_capture_unit: RTL and testbench

- Downstream consumer of the free-running 4-bit synchronous counter output `q`.
- Timestamps rising edges of an asynchronous event input using the counter value.
- Extends the timestamp with an epoch field that increments each time the counter wraps.
- Buffers timestamps in a small FIFO and delivers them over a valid/ready interface to the next stage (display/logging logic).

---
 rtl/capture_pkg.sv | 16 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/count_capture_unit.sv | 85 ++++++++
 tb/tb_count_capture_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared constants and the timestamp layout for the count capture unit.
// The default widths here describe the stamp seen by the display/logging stage.
package capture_pkg;

    localparam int CNT_W_DEF       = 4;
    localparam int EPOCH_W_DEF     = 4;
    localparam int DEPTH_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TS_W            = EPOCH_W_DEF + CNT_W_DEF;

    typedef struct packed {
        logic [EPOCH_W_DEF-1:0] epoch;
        logic [CNT_W_DEF-1:0]   count;
    } timestamp_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead single-clock FIFO: pop_data is the head entry whenever empty=0.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Gating with empty keeps the output at zero out of reset without clearing storage.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; validity lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/count_capture_unit.sv
// Timestamps rising edges of an asynchronous event with {epoch, count} and
// queues them for a valid/ready consumer; epoch counts wraps of the counter.
module count_capture_unit
    import capture_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int EPOCH_W     = EPOCH_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CNT_W-1:0]          q_in,
    input  logic                      event_in,
    output logic [EPOCH_W+CNT_W-1:0]  ts_data,
    output logic                      ts_valid,
    input  logic                      ts_ready,
    output logic                      overflow,
    input  logic                      clr_ovf,
    output logic [$clog2(DEPTH):0]    level
);

    typedef struct packed {
        logic [EPOCH_W-1:0] epoch;
        logic [CNT_W-1:0]   count;
    } stamp_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   event_edge;
    logic [CNT_W-1:0]       q_prev;
    logic [EPOCH_W-1:0]     epoch;
    logic                   wrap_now;
    stamp_t                 stamp;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   push;
    logic                   drop;

    assign event_edge = sync_q[SYNC_STAGES-1] & ~sync_prev;
    assign wrap_now   = (q_prev == '1) && (q_in == '0);

    // The stamp folds in a wrap happening on this very edge, so it matches the new epoch.
    assign stamp.epoch = epoch + EPOCH_W'(wrap_now);
    assign stamp.count = q_in;

    assign ts_valid = ~fifo_empty;
    assign pop      = ts_valid & ts_ready;
    assign push     = event_edge & (~fifo_full | pop);
    assign drop     = event_edge & fifo_full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
            q_prev    <= '0;
            epoch     <= '0;
            overflow  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], event_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
            q_prev    <= q_in;
            epoch     <= epoch + EPOCH_W'(wrap_now);
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(stamp_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (stamp),
        .pop       (pop),
        .pop_data  (ts_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

endmodule

// File: tb/tb_count_capture_unit.sv
// Bench for count_capture_unit: directed scenarios plus random events and
// back-pressure, scored against an event-level model of stamps in a queue.
module tb_count_capture_unit;
    import capture_pkg::*;

    localparam int DEPTH   = 4;
    localparam int LATENCY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] q_in = 4'h0;
    logic       event_in = 1'b0;
    logic       ts_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] ts_data;
    logic       ts_valid;
    logic       overflow;
    logic [2:0] level;

    always #5 clk = ~clk;

    count_capture_unit dut (
        .clk      (clk),
        .rst      (rst),
        .q_in     (q_in),
        .event_in (event_in),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .level    (level)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: an event seen rising at edge N yields a stamp at edge N+LATENCY,
    // whose epoch is the number of 15->0 counter wraps seen so far.
    timestamp_t  mq[$];
    int unsigned pend[$];
    int unsigned edge_n = 0;
    bit          ev_last;
    logic [3:0]  prev_q;
    int unsigned wraps;
    bit          m_ovf;
    int          cnt = 0;

    function automatic void model_reset();
        mq.delete();
        pend.delete();
        ev_last = 1'b0;
        prev_q  = 4'h0;
        wraps   = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_edge();
        bit         pop;
        bit         due;
        bit         was_full;
        timestamp_t st;
        edge_n++;
        if (event_in && !ev_last) pend.push_back(edge_n + LATENCY);
        ev_last = event_in;
        if (prev_q == 4'hF && q_in == 4'h0) wraps++;
        prev_q   = q_in;
        st.epoch = 4'(wraps);
        st.count = q_in;
        was_full = (mq.size() == DEPTH);
        pop      = (mq.size() > 0) && ts_ready;
        due      = (pend.size() > 0) && (pend[0] == edge_n);
        if (due) void'(pend.pop_front());
        if (pop) void'(mq.pop_front());
        if (due && (!was_full || pop)) mq.push_back(st);
        if (due && was_full && !pop) m_ovf = 1'b1;
        else if (clr_ovf)            m_ovf = 1'b0;
    endfunction

    task automatic check_outputs();
        check("ts_valid", ts_valid, mq.size() > 0);
        check("level", level, mq.size());
        check("overflow", overflow, m_ovf);
        if (mq.size() > 0) check("ts_data", ts_data, mq[0]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        cnt  = (cnt + 1) % 16;
        q_in = 4'(cnt);
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_event(input int hi, input int lo);
        event_in = 1'b1;
        hold(hi);
        event_in = 1'b0;
        hold(lo);
    endtask

    // Asserts reset between edges and checks that outputs clear before the next edge.
    task automatic do_reset();
        event_in = 1'b0;
        ts_ready = 1'b0;
        clr_ovf  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", ts_valid, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_data", ts_data, 8'h00);
        model_reset();
        cnt  = 0;
        q_in = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int phase_left;
        int ready_pct;

        @(posedge clk);
        #1;
        do_reset();

        // Single event sampled at q_in=3 is stamped with q_in=5.
        hold(3);
        event_in = 1'b1;
        hold(3);
        check("single_data", ts_data, 8'h05);
        check("single_valid", ts_valid, 1'b1);
        check("single_level", level, 3'd1);
        hold(2);
        event_in = 1'b0;
        check("held_level", level, 3'd1);
        hold(2);
        ts_ready = 1'b1;
        hold(2);
        ts_ready = 1'b0;

        // Capture coinciding with the wrap picks up the new epoch.
        for (int i = 0; i < 16 && q_in != 4'd14; i++) step();
        event_in = 1'b1;
        hold(3);
        check("wrap_data", ts_data, 8'h10);
        event_in = 1'b0;
        hold(3);
        ts_ready = 1'b1;
        hold(1);
        ts_ready = 1'b0;
        event_in = 1'b1;
        hold(3);
        check("epoch_kept", ts_data[7:4], 4'h1);
        event_in = 1'b0;
        hold(2);

        // Overflow: five events into a stalled FIFO.
        ts_ready = 1'b1;
        hold(1);
        ts_ready = 1'b0;
        repeat (5) pulse_event(2, 3);
        check("ovf_level", level, 3'd4);
        check("ovf_flag", overflow, 1'b1);
        ts_ready = 1'b1;
        hold(4);
        check("drained", ts_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 1'b0);

        // Full FIFO with push and pop on the same edge.
        ts_ready = 1'b0;
        repeat (4) pulse_event(2, 3);
        check("full_level", level, 3'd4);
        event_in = 1'b1;
        hold(2);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        check("fullpp_level", level, 3'd4);
        check("fullpp_ovf", overflow, 1'b0);
        event_in = 1'b0;
        hold(2);
        ts_ready = 1'b1;
        hold(4);

        // Back-pressure with ready toggling.
        ts_ready = 1'b0;
        repeat (3) pulse_event(2, 2);
        for (int i = 0; i < 12; i++) begin
            ts_ready = i[0];
            step();
        end

        // Reset with three entries queued.
        ts_ready = 1'b1;
        hold(4);
        ts_ready = 1'b0;
        repeat (3) pulse_event(2, 2);
        check("pre_rst_level", level, 3'd3);
        do_reset();

        // Random events, ready and clear.
        phase_left = $urandom_range(2, 6);
        ready_pct  = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ready_pct = $urandom_range(0, 100);
            ts_ready = ($urandom_range(0, 99) < ready_pct);
            clr_ovf  = ($urandom_range(0, 31) == 0);
            if (phase_left == 0) begin
                event_in   = ~event_in;
                phase_left = $urandom_range(2, 6);
            end
            phase_left--;
            step();
        end
        clr_ovf = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
